// File: rtl/timer_ctrl.sv
// Timer/counter engine for the 8051: Timer 0/1 count registers, mode sequencing,
// external-pin edge counting and TF0/TF1 overflow flags.
module timer_ctrl #(
  parameter int CYC_DIV = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tmod,
  input  logic       i_tr0,
  input  logic       i_tr1,
  input  logic       i_int0_n,
  input  logic       i_int1_n,
  input  logic       i_t0_pin,
  input  logic       i_t1_pin,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_sel,
  input  logic [7:0] i_wr_data,
  input  logic [1:0] i_tf_clr,
  output logic [7:0] o_tl0,
  output logic [7:0] o_th0,
  output logic [7:0] o_tl1,
  output logic [7:0] o_th1,
  output logic       o_tf0,
  output logic       o_tf1
);
  localparam int PW = (CYC_DIV > 1) ? $clog2(CYC_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  logic [1:0] t0_sync, t1_sync;
  logic       t0_prev, t1_prev;
  logic       fall0, fall1;

  logic [7:0] tl0, th0, tl1, th1;
  logic [7:0] tl0_n, th0_n, tl1_n, th1_n;
  logic       tf0, tf1;
  logic       set0, set1, ovf1;

  logic       gate0, ct0, gate1, ct1;
  logic [1:0] m0, m1;
  logic       run0, run1, inc0, inc1;
  logic       wr_tl0, wr_th0, wr_tl1, wr_th1, wr0, wr1;

  assign gate1 = i_tmod[7];
  assign ct1   = i_tmod[6];
  assign m1    = i_tmod[5:4];
  assign gate0 = i_tmod[3];
  assign ct0   = i_tmod[2];
  assign m0    = i_tmod[1:0];

  assign tick = (presc == PW'(CYC_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) presc <= '0;
    else       presc <= tick ? '0 : presc + 1'b1;
  end

  // Pins are asynchronous: two sync flops, then a previous-value flop for falling-edge detect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t0_sync <= 2'b11;
      t1_sync <= 2'b11;
      t0_prev <= 1'b1;
      t1_prev <= 1'b1;
    end else begin
      t0_sync <= {t0_sync[0], i_t0_pin};
      t1_sync <= {t1_sync[0], i_t1_pin};
      t0_prev <= t0_sync[1];
      t1_prev <= t1_sync[1];
    end
  end

  assign fall0 = t0_prev & ~t0_sync[1];
  assign fall1 = t1_prev & ~t1_sync[1];

  assign run0 = i_tr0 & (~gate0 | i_int0_n);
  assign run1 = i_tr1 & (~gate1 | i_int1_n);
  assign inc0 = run0 & (ct0 ? fall0 : tick);
  assign inc1 = run1 & (ct1 ? fall1 : tick);

  assign wr_tl0 = i_wr_en & (i_wr_sel == 2'b00);
  assign wr_th0 = i_wr_en & (i_wr_sel == 2'b01);
  assign wr_tl1 = i_wr_en & (i_wr_sel == 2'b10);
  assign wr_th1 = i_wr_en & (i_wr_sel == 2'b11);
  assign wr0    = wr_tl0 | wr_th0;
  assign wr1    = wr_tl1 | wr_th1;

  always_comb begin
    tl0_n = tl0;
    th0_n = th0;
    tl1_n = tl1;
    th1_n = th1;
    set0  = 1'b0;
    set1  = 1'b0;
    ovf1  = 1'b0;

    case (m0)
      2'd0: if (inc0 && !wr0) begin
        {th0_n, tl0_n[4:0]} = {th0, tl0[4:0]} + 13'd1;
        set0 = ({th0, tl0[4:0]} == 13'h1FFF);
      end
      2'd1: if (inc0 && !wr0) begin
        {th0_n, tl0_n} = {th0, tl0} + 16'd1;
        set0 = ({th0, tl0} == 16'hFFFF);
      end
      2'd2: if (inc0 && !wr0) begin
        tl0_n = (tl0 == 8'hFF) ? th0 : tl0 + 8'd1;
        set0  = (tl0 == 8'hFF);
      end
      default: begin
        // Split mode: TL0 is timer 0 proper; TH0 borrows TR1 and drives TF1.
        if (inc0 && !wr_tl0) begin
          tl0_n = tl0 + 8'd1;
          set0  = (tl0 == 8'hFF);
        end
        if (i_tr1 && tick && !wr_th0) begin
          th0_n = th0 + 8'd1;
          set1  = (th0 == 8'hFF);
        end
      end
    endcase

    if (inc1 && !wr1) begin
      case (m1)
        2'd0: begin
          {th1_n, tl1_n[4:0]} = {th1, tl1[4:0]} + 13'd1;
          ovf1 = ({th1, tl1[4:0]} == 13'h1FFF);
        end
        2'd1: begin
          {th1_n, tl1_n} = {th1, tl1} + 16'd1;
          ovf1 = ({th1, tl1} == 16'hFFFF);
        end
        2'd2: begin
          tl1_n = (tl1 == 8'hFF) ? th1 : tl1 + 8'd1;
          ovf1  = (tl1 == 8'hFF);
        end
        default: ;
      endcase
    end
    // Timer 1 loses TF1 to TH0 while timer 0 is split.
    if (m0 != 2'd3) set1 = set1 | ovf1;

    if (wr_tl0) tl0_n = i_wr_data;
    if (wr_th0) th0_n = i_wr_data;
    if (wr_tl1) tl1_n = i_wr_data;
    if (wr_th1) th1_n = i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tl0 <= 8'h00;
      th0 <= 8'h00;
      tl1 <= 8'h00;
      th1 <= 8'h00;
      tf0 <= 1'b0;
      tf1 <= 1'b0;
    end else begin
      tl0 <= tl0_n;
      th0 <= th0_n;
      tl1 <= tl1_n;
      th1 <= th1_n;
      tf0 <= (tf0 & ~i_tf_clr[0]) | set0;
      tf1 <= (tf1 & ~i_tf_clr[1]) | set1;
    end
  end

  assign o_tl0 = tl0;
  assign o_th0 = th0;
  assign o_tl1 = tl1;
  assign o_th1 = th1;
  assign o_tf0 = tf0;
  assign o_tf1 = tf1;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: modes 0-3, gating, pin counting, write/clear collisions, reset.
module tb_timer_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_tmod = 8'h00;
  logic       i_tr0 = 1'b0, i_tr1 = 1'b0;
  logic       i_int0_n = 1'b1, i_int1_n = 1'b1;
  logic       i_t0_pin = 1'b1, i_t1_pin = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [1:0] i_wr_sel = 2'b00;
  logic [7:0] i_wr_data = 8'h00;
  logic [1:0] i_tf_clr = 2'b00;
  logic [7:0] o_tl0, o_th0, o_tl1, o_th1;
  logic       o_tf0, o_tf1;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int ph = 0;

  timer_ctrl #(.CYC_DIV(12)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tmod(i_tmod), .i_tr0(i_tr0), .i_tr1(i_tr1),
    .i_int0_n(i_int0_n), .i_int1_n(i_int1_n), .i_t0_pin(i_t0_pin), .i_t1_pin(i_t1_pin),
    .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_data(i_wr_data), .i_tf_clr(i_tf_clr),
    .o_tl0(o_tl0), .o_th0(o_th0), .o_tl1(o_tl1), .o_th1(o_th1), .o_tf0(o_tf0), .o_tf1(o_tf1)
  );

  always #5 i_clk = ~i_clk;

  // Machine-cycle phase the bench expects: 0 after reset, tick edge follows phase 11.
  always @(posedge i_clk) begin
    if (i_rst) ph <= 0;
    else       ph <= (ph == 11) ? 0 : ph + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [7:0] data);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_data = data;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic clear_tf();
    i_tf_clr = 2'b11;
    @(negedge i_clk);
    i_tf_clr = 2'b00;
  endtask

  task automatic wait_pre_tick();
    for (int i = 0; i < 20 && ph != 11; i++) @(negedge i_clk);
    if (ph != 11) begin
      chk_cnt++;
      $display("FAIL tick_wait phase got %0d want 11", ph);
    end
  endtask

  task automatic to_tick();
    wait_pre_tick();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    idle(3);
    i_rst = 1'b0;
    chk_cnt++; if ({o_tl0, o_th0, o_tl1, o_th1} !== 32'h0) $display("FAIL rst_regs got %h want 00000000", {o_tl0, o_th0, o_tl1, o_th1}); else pass_cnt++;
    chk_cnt++; if ({o_tf0, o_tf1} !== 2'b00) $display("FAIL rst_tf got %b want 00", {o_tf0, o_tf1}); else pass_cnt++;
  endtask

  task automatic test_mode1();
    i_tmod = 8'h01;
    do_write(2'b01, 8'hFF);
    do_write(2'b00, 8'hFE);
    i_tr0 = 1'b1;
    to_tick();
    chk_cnt++; if ({o_th0, o_tl0, o_tf0} !== {16'hFFFF, 1'b0}) $display("FAIL m1_tick1 got %h/%b want ffff/0", {o_th0, o_tl0}, o_tf0); else pass_cnt++;
    to_tick();
    chk_cnt++; if ({o_th0, o_tl0, o_tf0} !== {16'h0000, 1'b1}) $display("FAIL m1_wrap got %h/%b want 0000/1", {o_th0, o_tl0}, o_tf0); else pass_cnt++;
    i_tf_clr = 2'b01;
    @(negedge i_clk);
    i_tf_clr = 2'b00;
    chk_cnt++; if (o_tf0 !== 1'b0) $display("FAIL m1_tf_clr got %b want 0", o_tf0); else pass_cnt++;
    i_tr0 = 1'b0;
  endtask

  task automatic test_mode2();
    i_tmod = 8'h20;
    do_write(2'b11, 8'hF0);
    do_write(2'b10, 8'hFE);
    i_tr1 = 1'b1;
    to_tick();
    chk_cnt++; if ({o_tl1, o_tf1} !== {8'hFF, 1'b0}) $display("FAIL m2_tick1 got %h/%b want ff/0", o_tl1, o_tf1); else pass_cnt++;
    to_tick();
    chk_cnt++; if ({o_th1, o_tl1, o_tf1} !== {16'hF0F0, 1'b1}) $display("FAIL m2_reload got %h/%b want f0f0/1", {o_th1, o_tl1}, o_tf1); else pass_cnt++;
    to_tick();
    chk_cnt++; if (o_tl1 !== 8'hF1) $display("FAIL m2_tick3 got %h want f1", o_tl1); else pass_cnt++;
    i_tr1 = 1'b0;
    clear_tf();
  endtask

  task automatic test_mode0();
    i_tmod = 8'h00;
    do_write(2'b01, 8'hFF);
    do_write(2'b00, 8'hBF);
    i_tr0 = 1'b1;
    to_tick();
    chk_cnt++; if ({o_th0, o_tl0, o_tf0} !== {16'h00A0, 1'b1}) $display("FAIL m0_wrap got %h/%b want 00a0/1", {o_th0, o_tl0}, o_tf0); else pass_cnt++;
    i_tr0 = 1'b0;
    clear_tf();
  endtask

  task automatic test_gate();
    i_tmod = 8'h09;
    do_write(2'b00, 8'h00);
    do_write(2'b01, 8'h00);
    i_int0_n = 1'b0;
    i_tr0 = 1'b1;
    idle(48);
    chk_cnt++; if (o_tl0 !== 8'h00) $display("FAIL gate_hold got %h want 00", o_tl0); else pass_cnt++;
    i_int0_n = 1'b1;
    to_tick();
    chk_cnt++; if (o_tl0 !== 8'h01) $display("FAIL gate_run1 got %h want 01", o_tl0); else pass_cnt++;
    idle(12);
    chk_cnt++; if (o_tl0 !== 8'h02) $display("FAIL gate_run2 got %h want 02", o_tl0); else pass_cnt++;
    i_tr0 = 1'b0;
  endtask

  task automatic test_counter();
    i_tmod = 8'h05;
    do_write(2'b00, 8'h00);
    i_tr0 = 1'b1;
    idle(4);
    i_t0_pin = 1'b0;
    idle(2);
    chk_cnt++; if (o_tl0 !== 8'h00) $display("FAIL cnt_latency_early got %h want 00", o_tl0); else pass_cnt++;
    idle(1);
    chk_cnt++; if (o_tl0 !== 8'h01) $display("FAIL cnt_latency got %h want 01", o_tl0); else pass_cnt++;
    idle(1);
    for (int k = 0; k < 2; k++) begin
      i_t0_pin = 1'b1; idle(4);
      i_t0_pin = 1'b0; idle(4);
    end
    i_t0_pin = 1'b1; idle(4);
    chk_cnt++; if (o_tl0 !== 8'h03) $display("FAIL cnt_three got %h want 03", o_tl0); else pass_cnt++;
    i_t0_pin = 1'b0; idle(20);
    chk_cnt++; if (o_tl0 !== 8'h04) $display("FAIL cnt_held_low got %h want 04", o_tl0); else pass_cnt++;
    i_t0_pin = 1'b1; idle(4);
    i_tr0 = 1'b0;
  endtask

  task automatic test_mode3();
    i_tmod = 8'h03;
    do_write(2'b00, 8'h12);
    do_write(2'b01, 8'hFF);
    do_write(2'b10, 8'h00);
    do_write(2'b11, 8'h00);
    i_tr1 = 1'b1;
    to_tick();
    chk_cnt++; if ({o_th0, o_tl0, o_tf1, o_tf0} !== {16'h0012, 2'b10}) $display("FAIL m3_th0 got %h/%b%b want 0012/10", {o_th0, o_tl0}, o_tf1, o_tf0); else pass_cnt++;
    i_tr1 = 1'b0;
    clear_tf();
    do_write(2'b11, 8'hFF);
    do_write(2'b10, 8'h1F);
    i_tr1 = 1'b1;
    to_tick();
    chk_cnt++; if ({o_th1, o_tl1, o_th0, o_tf1} !== {24'h000001, 1'b0}) $display("FAIL m3_t1_no_tf got %h/%b want 000001/0", {o_th1, o_tl1, o_th0}, o_tf1); else pass_cnt++;
    i_tr1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    i_tmod = 8'h01;
    clear_tf();
    do_write(2'b00, 8'hFF);
    do_write(2'b01, 8'hFF);
    i_tr0 = 1'b1;
    wait_pre_tick();
    i_tf_clr = 2'b01;
    @(negedge i_clk);
    i_tf_clr = 2'b00;
    chk_cnt++; if ({o_th0, o_tl0, o_tf0} !== {16'h0000, 1'b1}) $display("FAIL clr_vs_set got %h/%b want 0000/1", {o_th0, o_tl0}, o_tf0); else pass_cnt++;
    wait_pre_tick();
    do_write(2'b00, 8'h55);
    chk_cnt++; if ({o_th0, o_tl0} !== 16'h0055) $display("FAIL wr_vs_tick got %h want 0055", {o_th0, o_tl0}); else pass_cnt++;
    to_tick();
    chk_cnt++; if (o_tl0 !== 8'h56) $display("FAIL wr_then_tick got %h want 56", o_tl0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wait_pre_tick();
    i_rst = 1'b1;
    i_wr_en = 1'b1; i_wr_sel = 2'b01; i_wr_data = 8'hAA;
    @(negedge i_clk);
    i_wr_en = 1'b0;
    i_rst = 1'b0;
    chk_cnt++; if ({o_tl0, o_th0, o_tf0} !== {16'h0000, 1'b0}) $display("FAIL rst_mid got %h/%b want 0000/0", {o_th0, o_tl0}, o_tf0); else pass_cnt++;
    i_tr0 = 1'b0;
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_mode1();
    test_mode2();
    test_mode0();
    test_gate();
    test_counter();
    test_mode3();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Timer/counter engine for the 8051 core: owns Timer 0 and Timer 1 count registers (TL0/TH0/TL1/TH1) and sequences them per the TMOD byte and the TCON run bits. Sits beside the SFR block, taking TMOD and TR0/TR1 as configuration and exposing count registers and overflow flags TF0/TF1 to the SFR read mux and interrupt controller.

## Interface
- CYC_DIV, 12: clocks per machine cycle; timer-mode increment rate.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_tmod  in  8  TMOD: [7]GATE1 [6]C/T1 [5:4]M1 / [3]GATE0 [2]C/T0 [1:0]M0
- i_tr0, i_tr1  in  1 each  TCON run bits
- i_int0_n, i_int1_n  in  1 each  INT pin levels (gate inputs, already synchronous)
- i_t0_pin, i_t1_pin  in  1 each  external count pins (asynchronous)
- i_wr_en  in  1  count-register write strobe
- i_wr_sel  in  2  00 TL0, 01 TH0, 10 TL1, 11 TH1
- i_wr_data  in  8  write data
- i_tf_clr  in  2  [0] clear TF0, [1] clear TF1 (ISR vector or software)
- o_tl0, o_th0, o_tl1, o_th1  out  8 each  count registers
- o_tf0, o_tf1  out  1 each  overflow flags

## Operation
- Prescaler: counter 0..CYC_DIV-1, free-running from reset; `tick` high the cycle it equals CYC_DIV-1, then wraps to 0.
- Pin input: 2-flop synchronizer per pin, plus a previous-value flop; `edge` = prev & ~sync (falling edge); one increment per edge.
- Run enable per timer x: run_x = TRx & (~GATEx | INTx_n).
- Increment event inc_x = run_x & (C/Tx ? edge_x : tick).
- Mode 0 (13-bit): TL[4:0] low bits, TH upper 8; TL[7:5] hold. On TH=FF & TL[4:0]=1F: wrap to 0, set TF.
- Mode 1 (16-bit): TH:TL increments; FFFF -> 0000 sets TF.
- Mode 2 (8-bit auto-reload): TL increments; on TL=FF, TL <= TH, TF set; TH never changes from counting.
- Mode 3, Timer 0: TL0 is 8-bit timer/counter using TR0/GATE0/C/T0, sets TF0 on FF->00. TH0 is 8-bit timer on `tick` only, enabled by TR1 alone (no gate), sets TF1 on FF->00.
- Mode 3, Timer 1: halted, registers hold.
- While Timer 0 is in mode 3, Timer 1 counts per its own mode 0-2 but never sets TF1.
- Writes: i_wr_en loads the selected byte. A write to any byte of a timer suppresses that timer's increment that cycle (both bytes hold except the written one). In Timer 0 mode 3, a write to TL0 suppresses only TL0; a write to TH0 suppresses only TH0.
- TF: set on overflow, cleared by i_tf_clr; simultaneous set and clear leaves TF = 1.
- Mode/TMOD changes take effect on the next increment; no register is altered by a mode change alone.

## Timing
- Reset: all count registers 00, o_tf0 = o_tf1 = 0, prescaler 0, synchronizer and previous-value flops 1.
- Reset mid-count overrides any pending increment, write or flag set.
- Counter latency: increment lands on the clock edge where `tick` is high. Overflow, reload and TF set occur on the same edge; all are visible the following cycle.
- Pin latency: a falling pin first sampled low at edge n updates the count at edge n+2, visible after n+2. A pin held low for many cycles counts once.
- The pin must be high ≥2 clocks and low ≥2 clocks per count.
- A write is visible the cycle after i_wr_en. A TF clear is visible the cycle after i_tf_clr.

## Test plan
- Mode 1: TMOD=01, write TH0=FF, TL0=FE, TR0=1 -> after tick 1 TL0=FF, TF0=0; after tick 2 TH0:TL0=0000, TF0=1; i_tf_clr[0] -> TF0=0 next cycle.
- Mode 2: TMOD=20, TH1=F0, TL1=FE, TR1=1 -> tick 2 gives TL1=F0, TF1=1, TH1=F0; tick 3 gives TL1=F1.
- Mode 0: TMOD=00, TH0=FF, TL0=BF, TR0=1 -> next tick TH0=00, TL0=A0, TF0=1.
- Gate: TMOD=09, TR0=1, INT0_n=0 -> TL0 unchanged over 48 clocks; INT0_n=1 -> TL0 increments every 12 clocks.
- Counter: TMOD=05, TR0=1, three falling edges on T0 (4 clocks high/low each) -> TL0=03; T0 held low 20 clocks -> one increment only.
- Mode 3 and collisions:
  - TMOD=03, TR0=0, TR1=1, TH0=FF -> next tick TH0=00, TF1=1, TL0 unchanged.
  - TF clear coincident with overflow -> TF stays 1.
  - Write TL0=55 on a tick cycle -> TL0=55, no increment.
